// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
// Accepts a byte on a valid/ready handshake and runs the host request-to-send
// sequence on open-drain PS/2 clock/data: inhibit, start, 8 data bits (LSB
// first), odd parity, stop, device ACK. Start and frame timeouts are detected
// and the frame is retried up to MAX_RETRY times before reporting failure.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   tx_data/valid     byte to send and request (captured when tx_ready)
//   tx_ready          high while idle
//   ps2_clk_in/data   raw pad levels (synchronised internally)
//   ps2_clk_oe/data_oe 1 pulls the pad low, 0 releases it
//   busy              high from acceptance until done
//   done              one-cycle completion pulse
//   status            00 ACK, 01 NACK, 10 start timeout, 11 frame timeout
//   retries           attempts beyond the first, valid with done
module ps2_host_tx #(
   parameter int CLK_FREQ         = 50000000,
   parameter int INHIBIT_US       = 100,
   parameter int START_TIMEOUT_US = 15000,
   parameter int FRAME_TIMEOUT_US = 2000,
   parameter int MAX_RETRY        = 2,
   parameter int SYNC_STAGES      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   output logic [1:0] retries
);

   localparam int CYC_US   = CLK_FREQ / 1000000;
   localparam int INHIBIT  = CYC_US * INHIBIT_US;
   localparam int START_TO = CYC_US * START_TIMEOUT_US;
   localparam int FRAME_TO = CYC_US * FRAME_TIMEOUT_US;
   localparam int INH_W    = $clog2(INHIBIT + 1);
   localparam int ST_W     = $clog2(START_TO + 1);
   localparam int FR_W     = $clog2(FRAME_TO + 1);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT - 1);
   localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(START_TO - 1);
   localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(FRAME_TO - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   // input synchroniser; idle bus level is 1
   logic [SYNC_STAGES-1:0] csync_q, dsync_q;
   logic                   cprev_q;
   logic                   sclk, sdata, fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csync_q <= '1;
         dsync_q <= '1;
         cprev_q <= 1'b1;
      end else begin
         csync_q <= (csync_q << 1) | SYNC_STAGES'(ps2_clk_in);
         dsync_q <= (dsync_q << 1) | SYNC_STAGES'(ps2_data_in);
         cprev_q <= sclk;
      end
   end

   assign sclk  = csync_q[SYNC_STAGES-1];
   assign sdata = dsync_q[SYNC_STAGES-1];
   assign fall  = cprev_q & ~sclk;

   state_t            state_q, state_d;
   logic [7:0]        byte_q, byte_d;
   logic              par_q, par_d;
   logic [3:0]        bit_q, bit_d;
   logic              dout_q, dout_d;
   logic [INH_W-1:0]  inh_q, inh_d;
   logic [ST_W-1:0]   st_q, st_d;
   logic [FR_W-1:0]   fr_q, fr_d;
   logic [1:0]        retry_q, retry_d;
   logic [1:0]        status_q, status_d;
   logic              done_q, done_d;
   logic              fail, frame_live, evt;
   logic [1:0]        fail_code;

   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      par_d      = par_q;
      bit_d      = bit_q;
      dout_d     = dout_q;
      inh_d      = inh_q;
      st_d       = st_q;
      fr_d       = fr_q;
      retry_d    = retry_q;
      status_d   = status_q;
      done_d     = 1'b0;
      fail       = 1'b0;
      fail_code  = 2'b00;
      frame_live = 1'b0;
      evt        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               byte_d  = tx_data;
               par_d   = ~^tx_data;
               retry_d = 2'd0;
               inh_d   = '0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_q == INH_LAST) state_d = S_START;
            else                   inh_d   = inh_q + 1'b1;
         end
         S_START: begin
            dout_d  = 1'b1;               // start bit held through release
            bit_d   = 4'd0;
            st_d    = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            frame_live = (bit_q != 4'd0);
            evt        = fall;
            if (fall) begin
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd0) fr_d = '0;   // frame timer starts at edge 1
               if (bit_q < 4'd8)       dout_d = ~byte_q[bit_q[2:0]];
               else if (bit_q == 4'd8) dout_d = ~par_q;
               else begin
                  dout_d  = 1'b0;              // stop bit
                  state_d = S_ACK;
               end
            end else if (bit_q == 4'd0) begin
               if (st_q == ST_LAST) begin
                  fail      = 1'b1;
                  fail_code = 2'b10;
               end else begin
                  st_d = st_q + 1'b1;
               end
            end
         end
         S_ACK: begin
            frame_live = 1'b1;
            evt        = fall;
            if (fall) begin
               if (!sdata) state_d = S_WAIT_IDLE;
               else begin
                  fail      = 1'b1;
                  fail_code = 2'b01;
               end
            end
         end
         S_WAIT_IDLE: begin
            frame_live = 1'b1;
            evt        = sclk & sdata;
            if (sclk && sdata) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               status_d = 2'b00;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Frame timer saturates at its last count; a bus event in the expiry
      // cycle wins, and the next quiet cycle then times out.
      if (frame_live) begin
         if (fr_q < FR_LAST) fr_d = fr_q + 1'b1;
         if (!evt && fr_q >= FR_LAST) begin
            fail      = 1'b1;
            fail_code = 2'b11;
         end
      end

      if (fail) begin
         if (retry_q < 2'(MAX_RETRY)) begin
            retry_d = retry_q + 2'd1;
            inh_d   = '0;
            state_d = S_INHIBIT;
         end else begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            status_d = fail_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         byte_q   <= '0;
         par_q    <= 1'b0;
         bit_q    <= '0;
         dout_q   <= 1'b0;
         inh_q    <= '0;
         st_q     <= '0;
         fr_q     <= '0;
         retry_q  <= '0;
         status_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         byte_q   <= byte_d;
         par_q    <= par_d;
         bit_q    <= bit_d;
         dout_q   <= dout_d;
         inh_q    <= inh_d;
         st_q     <= st_d;
         fr_q     <= fr_d;
         retry_q  <= retry_d;
         status_q <= status_d;
         done_q   <= done_d;
      end
   end

   // pad enables decode from state so reset releases the bus at once
   assign tx_ready    = (state_q == S_IDLE);
   assign busy        = ~tx_ready;
   assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
   assign ps2_data_oe = (state_q == S_START) ||
                        (((state_q == S_SEND) || (state_q == S_ACK)) && dout_q);
   assign done        = done_q;
   assign status      = status_q;
   assign retries     = retry_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int CF = 1000000;   // 1 cycle = 1 us

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0, tx_valid0 = 1'b0;
   logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;

   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done;
   logic [1:0] status, retries;
   logic       tx_ready0, clk_oe0, data_oe0, busy0, done0;
   logic [1:0] status0, retries0;
   logic       pad_clk, pad_data;

   // shared open-drain bus; only one host is active at a time
   assign pad_clk  = ~(ps2_clk_oe | clk_oe0 | dev_clk_low);
   assign pad_data = ~(ps2_data_oe | data_oe0 | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.CLK_FREQ(CF)) dut (
      .clk(clk), .rst(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .ps2_clk_in(pad_clk), .ps2_data_in(pad_data),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
      .done(done), .status(status), .retries(retries));

   ps2_host_tx #(.CLK_FREQ(CF), .MAX_RETRY(0)) dut0 (
      .clk(clk), .rst(rst_n), .tx_data(tx_data), .tx_valid(tx_valid0),
      .tx_ready(tx_ready0), .ps2_clk_in(pad_clk), .ps2_data_in(pad_data),
      .ps2_clk_oe(clk_oe0), .ps2_data_oe(data_oe0), .busy(busy0),
      .done(done0), .status(status0), .retries(retries0));

   int vec = 0, miss = 0;
   int cyc = 0, done_cnt = 0, done0_cnt = 0, done0_cyc = 0, edge1_cyc = 0;
   logic [3:0]  exp_q[$];    // {status, retries}
   logic [3:0]  exp0_q[$];
   logic [10:0] frm_q[$];    // bit i = i-th bit the device samples

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitors: pop expected completion on every done pulse
   initial forever begin
      logic [3:0] e;
      @(negedge clk);
      if (done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            vec++; miss++;
            $display("FAIL done_unexpected: status %b retries %0d, none expected", status, retries);
         end else begin
            e = exp_q.pop_front();
            chk("done_status", 32'(status), 32'(e[3:2]));
            chk("done_retries", 32'(retries), 32'(e[1:0]));
            chk("ready_with_done", 32'(tx_ready), 32'd1);
         end
      end
   end

   initial forever begin
      logic [3:0] e;
      @(negedge clk);
      if (done0 === 1'b1) begin
         done0_cnt++;
         done0_cyc = cyc;
         if (exp0_q.size() == 0) begin
            vec++; miss++;
            $display("FAIL done0_unexpected: status %b retries %0d, none expected", status0, retries0);
         end else begin
            e = exp0_q.pop_front();
            chk("done0_status", 32'(status0), 32'(e[3:2]));
            chk("done0_retries", 32'(retries0), 32'(e[1:0]));
         end
      end
   end

   // every completed inhibit phase must last 100 cycles before the start bit
   initial begin
      int inh_run;
      inh_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) inh_run = 0;
         else if (ps2_clk_oe && !ps2_data_oe) inh_run++;
         else begin
            if (inh_run != 0 && ps2_clk_oe && ps2_data_oe) chk("inhibit_len", 32'(inh_run), 32'd100);
            inh_run = 0;
         end
      end
   end

   // device model: 20-cycle clock period, samples data just before each rising edge
   task automatic dev_frame(input bit ack, input int stop_after);
      int n;
      logic [10:0] smp;
      smp = '0;
      n = 0;
      while (pad_clk !== 1'b0 && n < 40000) begin @(posedge clk); #1; n++; end
      while (pad_clk !== 1'b1 && n < 40000) begin @(posedge clk); #1; n++; end
      if (n >= 40000) begin
         vec++; miss++;
         $display("FAIL dev_wait_release: no inhibit/release within %0d cycles", n);
         return;
      end
      smp[0] = pad_data;
      repeat (5) @(posedge clk);
      #1;
      for (int e = 1; e <= 11; e++) begin
         if (e > stop_after) break;
         dev_clk_low = 1'b1;
         if (e == 11 && ack) dev_data_low = 1'b1;
         if (e == 1) edge1_cyc = cyc;
         repeat (10) @(posedge clk);
         #1;
         if (e <= 10) smp[e] = pad_data;
         dev_clk_low  = 1'b0;
         dev_data_low = 1'b0;
         repeat (10) @(posedge clk);
         #1;
      end
      if (stop_after >= 11) begin
         if (frm_q.size() == 0) begin
            vec++; miss++;
            $display("FAIL frame_unexpected: sampled %b, none expected", smp);
         end else chk("frame_bits", 32'(smp), 32'(frm_q.pop_front()));
      end
   endtask

   // drive a request and return just after the accepting edge
   task automatic send(input logic [7:0] b, input bit d0, input bit chk_done);
      int n;
      n = 0;
      tx_data = b;
      if (d0) tx_valid0 = 1'b1; else tx_valid = 1'b1;
      @(negedge clk);
      while ((d0 ? tx_ready0 : tx_ready) !== 1'b1 && n < 60000) begin @(negedge clk); n++; end
      if (n >= 60000) begin
         vec++; miss++;
         $display("FAIL accept_timeout: byte %h not accepted", b);
      end
      if (chk_done) chk("accept_in_done_cycle", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int target, input bit d0);
      int n;
      n = 0;
      while ((d0 ? done0_cnt : done_cnt) < target && n < 60000) begin @(posedge clk); n++; end
      if (n >= 60000) begin
         vec++; miss++;
         $display("FAIL done_timeout: count %0d never reached %0d", d0 ? done0_cnt : done_cnt, target);
      end
      #1;
   endtask

   // {stop, parity, data LSB-first, start}; parity given by hand
   function automatic logic [10:0] mk(input logic [7:0] b, input logic par);
      return {1'b1, par, b, 1'b0};
   endfunction

   initial begin
      int n;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_status_retries", 32'({status, retries}), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 0xED: samples 0,1,0,1,1,0,1,1,1,1,1
      frm_q.push_back(11'b111_1101_1010);
      exp_q.push_back(4'b00_00);
      fork
         dev_frame(1'b1, 11);
         begin send(8'hED, 1'b0, 1'b0); chk("busy_after_accept", 32'(busy), 32'd1); tx_valid = 1'b0; end
      join
      wait_done(1, 1'b0);

      // back-to-back with tx_valid held: 00 (p1), FF (p1), 01 (p0)
      frm_q.push_back(mk(8'h00, 1'b1));
      frm_q.push_back(mk(8'hFF, 1'b1));
      frm_q.push_back(mk(8'h01, 1'b0));
      repeat (3) exp_q.push_back(4'b00_00);
      fork
         begin dev_frame(1'b1, 11); dev_frame(1'b1, 11); dev_frame(1'b1, 11); end
         begin
            send(8'h00, 1'b0, 1'b0);
            send(8'hFF, 1'b0, 1'b1);
            send(8'h01, 1'b0, 1'b1);
            tx_valid = 1'b0;
         end
      join
      wait_done(4, 1'b0);

      // NACK on first attempt, ACK on retry: same byte twice, retries=1
      frm_q.push_back(mk(8'h3C, 1'b1));
      frm_q.push_back(mk(8'h3C, 1'b1));
      exp_q.push_back(4'b00_01);
      fork
         begin dev_frame(1'b0, 11); dev_frame(1'b1, 11); end
         begin send(8'h3C, 1'b0, 1'b0); tx_valid = 1'b0; end
      join
      wait_done(5, 1'b0);

      // reset mid-SEND: after edge 3 the line carries ~0x5A[2] = 1
      fork
         dev_frame(1'b1, 3);
         begin send(8'h5A, 1'b0, 1'b0); tx_valid = 1'b0; end
      join
      chk("send_data_oe_before_rst", 32'(ps2_data_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 32'(tx_ready), 32'd1);
      repeat (50) @(posedge clk);
      #1;

      // device stops after edge 5, no retry: done at edge1 + 2000 + sync(2) + edge reg(1)
      exp0_q.push_back(4'b11_00);
      fork
         dev_frame(1'b1, 5);
         begin send(8'h96, 1'b1, 1'b0); tx_valid0 = 1'b0; end
      join
      wait_done(1, 1'b1);
      chk("frame_timeout_cycles", 32'(done0_cyc - edge1_cyc), 32'd2003);

      // no device: three attempts each ending 15000 cycles after clock release
      exp_q.push_back(4'b10_10);
      send(8'hA5, 1'b0, 1'b0);
      tx_valid = 1'b0;
      for (int a = 0; a < 3; a++) begin
         n = 0;
         @(negedge clk);
         while (ps2_clk_oe !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
         n = 0;
         do begin @(negedge clk); n++; end
         while (ps2_clk_oe !== 1'b1 && done !== 1'b1 && n < 20000);
         chk("start_timeout_gap", 32'(n), 32'd15000);
      end
      wait_done(6, 1'b0);
      @(negedge clk);
      chk("oe_after_fail", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

      chk("scoreboard_drained", 32'(exp_q.size() + exp0_q.size() + frm_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
